// File: rtl/processor_control_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : processor_ctrl_pkg                                     |
// | Description : State codes, opcodes and datapath control encodings    |
// |               shared by the multi-cycle control FSM and its helpers. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package processor_ctrl_pkg;

   // Controller state codes; also exported on the debug state port
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_WB     = 4'd4,
      S_MADDR  = 4'd5,
      S_MRD    = 4'd6,
      S_MWR    = 4'd7,
      S_BR     = 4'd8,
      S_JMP    = 4'd9,
      S_HALT   = 4'd10,
      S_TRAP   = 4'd11
   } state_t;

   // Opcodes, IR[15:12]; 0xB..0xE are undefined
   localparam logic [3:0] c_op_add  = 4'h0;
   localparam logic [3:0] c_op_sub  = 4'h1;
   localparam logic [3:0] c_op_and  = 4'h2;
   localparam logic [3:0] c_op_or   = 4'h3;
   localparam logic [3:0] c_op_addi = 4'h4;
   localparam logic [3:0] c_op_lw   = 4'h5;
   localparam logic [3:0] c_op_sw   = 4'h6;
   localparam logic [3:0] c_op_beqz = 4'h7;
   localparam logic [3:0] c_op_j    = 4'h8;
   localparam logic [3:0] c_op_jr   = 4'h9;
   localparam logic [3:0] c_op_li   = 4'hA;
   localparam logic [3:0] c_op_halt = 4'hF;

   // ALU function select
   localparam logic [2:0] c_alu_pass = 3'd0;
   localparam logic [2:0] c_alu_add  = 3'd1;
   localparam logic [2:0] c_alu_sub  = 3'd2;
   localparam logic [2:0] c_alu_and  = 3'd3;
   localparam logic [2:0] c_alu_or   = 3'd4;

   // Next-PC source select
   localparam logic [1:0] c_jc_pc1 = 2'd0;   // PC+1
   localparam logic [1:0] c_jc_rel = 2'd1;   // PC+sext(IR[11:0])
   localparam logic [1:0] c_jc_abs = 2'd2;   // IR[11:0]
   localparam logic [1:0] c_jc_reg = 2'd3;   // A register

   // Register write-back source select
   localparam logic [2:0] c_dd_alu = 3'd0;
   localparam logic [2:0] c_dd_mem = 3'd1;
   localparam logic [2:0] c_dd_imm = 3'd2;

   // Only ADD, SUB and ADDI can raise an arithmetic overflow trap
   function automatic logic can_overflow(input logic [3:0] op);
      return (op == c_op_add) || (op == c_op_sub) || (op == c_op_addi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/processor_control_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : processor_control_fsm_if                               |
// | Description : Controller <-> datapath/system bus. The master modport |
// |               is the control FSM; the slave modport is the datapath  |
// |               and system controller. trap exists only when           |
// |               PROC_CTRL_OVF_TRAP_EN is defined.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface processor_control_fsm_if #(
   parameter int OPC_W = 4
);
   // status into the controller
   logic             run;
   logic [OPC_W-1:0] opcode;
   logic [1:0]       irDest;      // IR[11:10], destination register field
   logic             isZero;
   logic             overflow;

   // datapath strobes and selects
   logic       IRwrite;
   logic       PCwrite;
   logic       Awrite;
   logic       Bwrite;
   logic       ALUwrite;
   logic       Mwrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       isZeroWrite;
   logic       IorM;
   logic       Asel;
   logic       Bsel;
   logic       ItypeSel;
   logic [2:0] ALUctrl;
   logic [1:0] jControl;
   logic [1:0] destAddr;
   logic [2:0] destData;

   // system handshakes
   logic       halted;
   logic       illegal;
   logic [3:0] state;
`ifdef PROC_CTRL_OVF_TRAP_EN
   logic       trap;
`endif

   modport master (
`ifdef PROC_CTRL_OVF_TRAP_EN
      output trap,
`endif
      input  run, opcode, irDest, isZero, overflow,
      output IRwrite, PCwrite, Awrite, Bwrite, ALUwrite, Mwrite, MemWrite,
             RegWrite, isZeroWrite, IorM, Asel, Bsel, ItypeSel, ALUctrl,
             jControl, destAddr, destData, halted, illegal, state
   );

   modport slave (
`ifdef PROC_CTRL_OVF_TRAP_EN
      input  trap,
`endif
      output run, opcode, irDest, isZero, overflow,
      input  IRwrite, PCwrite, Awrite, Bwrite, ALUwrite, Mwrite, MemWrite,
             RegWrite, isZeroWrite, IorM, Asel, Bsel, ItypeSel, ALUctrl,
             jControl, destAddr, destData, halted, illegal, state
   );

endinterface
`default_nettype wire

// File: rtl/processor_control_fsm_alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_op_decode                                          |
// | Description : Combinational opcode -> ALU function map for the       |
// |               execute step. ADDI shares the adder with ADD.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_op_decode
   import processor_ctrl_pkg::*;
(
   input  wire logic [3:0] i_opcode,
   output logic      [2:0] o_alu_ctrl
);

   // Map arithmetic/logic opcodes to their ALU function; all else passes
   always_comb begin
      o_alu_ctrl = c_alu_pass;
      case (i_opcode)
         c_op_add, c_op_addi: o_alu_ctrl = c_alu_add;
         c_op_sub:            o_alu_ctrl = c_alu_sub;
         c_op_and:            o_alu_ctrl = c_alu_and;
         c_op_or:             o_alu_ctrl = c_alu_or;
         default:             o_alu_ctrl = c_alu_pass;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/processor_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : processor_control_fsm                                  |
// | Description : Multi-cycle Moore control unit for the 16-bit          |
// |               accumulator datapath. Sequences fetch, decode,         |
// |               execute, memory and write-back strobes from IR[15:12]. |
// |               Optional overflow trap: define PROC_CTRL_OVF_TRAP_EN.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module processor_control_fsm
   import processor_ctrl_pkg::*;
#(
   parameter bit RESET_STATE_IDLE = 1'b1,
   parameter int OPC_W            = 4
) (
   input  wire logic               Clock,
   input  wire logic               Reset,
   processor_control_fsm_if.master bus
);

   state_t           r_state;
   state_t           w_next;
   logic [OPC_W-1:0] w_opcode;
   logic [2:0]       w_alu_exec;

   assign w_opcode = bus.opcode;

`ifndef PROC_CTRL_OVF_TRAP_EN
   // overflow has no consumer without the trap feature
   logic w_unused_ovf;
   assign w_unused_ovf = bus.overflow;
`endif

   alu_op_decode u_alu_op_decode (
      .i_opcode   (w_opcode[3:0]),
      .o_alu_ctrl (w_alu_exec)
   );

   // State register; reset abandons any instruction in flight
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_state <= RESET_STATE_IDLE ? S_IDLE : S_FETCH;
      else        r_state <= w_next;
   end

   // Next-state and Moore outputs from state plus the decoded opcode.
   // Outputs are held at zero while Reset is asserted.
   always_comb begin
      w_next          = r_state;
      bus.IRwrite     = 1'b0;
      bus.PCwrite     = 1'b0;
      bus.Awrite      = 1'b0;
      bus.Bwrite      = 1'b0;
      bus.ALUwrite    = 1'b0;
      bus.Mwrite      = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.isZeroWrite = 1'b0;
      bus.IorM        = 1'b0;
      bus.Asel        = 1'b0;
      bus.Bsel        = 1'b0;
      bus.ItypeSel    = 1'b0;
      bus.ALUctrl     = c_alu_pass;
      bus.jControl    = c_jc_pc1;
      bus.destAddr    = 2'd0;
      bus.destData    = c_dd_alu;
      bus.halted      = 1'b0;
      bus.illegal     = 1'b0;
      bus.state       = 4'd0;
`ifdef PROC_CTRL_OVF_TRAP_EN
      bus.trap        = 1'b0;
`endif
      if (Reset) begin
         bus.state = r_state;
         bus.Asel  = (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               bus.Asel = 1'b0;
               if (bus.run) w_next = S_FETCH;
            end
            S_FETCH: begin
               bus.IRwrite  = 1'b1;
               bus.PCwrite  = 1'b1;
               bus.IorM     = 1'b0;
               bus.jControl = c_jc_pc1;
               w_next       = S_DECODE;
            end
            S_DECODE: begin
               bus.Awrite = 1'b1;
               bus.Bwrite = 1'b1;
               bus.Bsel   = (w_opcode inside {c_op_addi, c_op_lw, c_op_sw});
               case (w_opcode)
                  c_op_add, c_op_sub, c_op_and, c_op_or, c_op_addi:
                                       w_next = S_EXEC;
                  c_op_lw, c_op_sw:    w_next = S_MADDR;
                  c_op_beqz:           w_next = S_BR;
                  c_op_j, c_op_jr:     w_next = S_JMP;
                  c_op_li:             w_next = S_WB;
                  c_op_halt:           w_next = S_HALT;
                  default: begin
                     // undefined opcode behaves as a NOP
                     bus.illegal = 1'b1;
                     w_next      = S_FETCH;
                  end
               endcase
            end
            S_EXEC: begin
               bus.ALUwrite    = 1'b1;
               bus.isZeroWrite = 1'b1;
               bus.ALUctrl     = w_alu_exec;
               w_next          = S_WB;
`ifdef PROC_CTRL_OVF_TRAP_EN
               if (bus.overflow && can_overflow(w_opcode[3:0])) w_next = S_TRAP;
`endif
            end
            S_WB: begin
               bus.RegWrite = 1'b1;
               bus.destAddr = bus.irDest;
               if (w_opcode == c_op_li)      bus.destData = c_dd_imm;
               else if (w_opcode == c_op_lw) bus.destData = c_dd_mem;
               else                          bus.destData = c_dd_alu;
               w_next = S_FETCH;
            end
            S_MADDR: begin
               bus.ALUctrl  = c_alu_add;
               bus.ALUwrite = 1'b1;
               w_next       = (w_opcode == c_op_lw) ? S_MRD : S_MWR;
            end
            S_MRD: begin
               bus.IorM   = 1'b1;
               bus.Mwrite = 1'b1;
               w_next     = S_WB;
            end
            S_MWR: begin
               bus.IorM     = 1'b1;
               bus.MemWrite = 1'b1;
               w_next       = S_FETCH;
            end
            S_BR: begin
               bus.PCwrite  = bus.isZero;
               bus.jControl = c_jc_rel;
               w_next       = S_FETCH;
            end
            S_JMP: begin
               bus.PCwrite  = 1'b1;
               bus.jControl = (w_opcode == c_op_jr) ? c_jc_reg : c_jc_abs;
               w_next       = S_FETCH;
            end
            S_HALT: begin
               // only Reset leaves HALT
               bus.halted = 1'b1;
               w_next     = S_HALT;
            end
`ifdef PROC_CTRL_OVF_TRAP_EN
            S_TRAP: begin
               bus.PCwrite  = 1'b1;
               bus.jControl = c_jc_abs;
               bus.trap     = 1'b1;
               w_next       = S_FETCH;
            end
`endif
            default: w_next = S_FETCH;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_processor_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_processor_control_fsm                               |
// | Description : Self-checking bench. Expected outputs come from a      |
// |               per-instruction timeline model (opcode, cycle index).  |
// |               Build with PROC_CTRL_OVF_TRAP_EN to cover the trap.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_processor_control_fsm;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   processor_control_fsm_if #(.OPC_W(4)) bus ();

   processor_control_fsm #(.RESET_STATE_IDLE(1'b1), .OPC_W(4)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   // expectation handed from stimulus to the compare process
   logic [24:0] exp_vec   = '0;
   logic        exp_trap  = 1'b0;
   logic        exp_chk_st = 1'b0;
   logic        exp_valid = 1'b0;
   logic        lat_arm   = 1'b0;
   int          fetch_t[$];

   // Cycles from one fetch to the next for a given opcode
   function automatic int ilen(input int op);
      case (op)
         0, 1, 2, 3, 4, 6: return 4;
         5:                return 5;
         7, 8, 9, 10:      return 3;
         default:          return 2;
      endcase
   endfunction

   // Expected outputs for cycle ph of an instruction with opcode op
   function automatic logic [24:0] model_out(input int op, input int ph,
                                             input logic [1:0] d, input logic z,
                                             input logic trapped);
      logic irw, pcw, aw, bw, alw, mw, memw, rw, zw, iorm, asel, bsel, its, hlt, ill;
      logic [2:0] alu;
      logic [1:0] jc;
      logic [1:0] da;
      logic [2:0] dd;
      {irw, pcw, aw, bw, alw, mw, memw, rw, zw, iorm, bsel, its, hlt, ill} = '0;
      alu = 3'd0; jc = 2'd0; da = 2'd0; dd = 3'd0;
      asel = 1'b1;
      if (ph == 0) begin
         irw = 1'b1; pcw = 1'b1;
      end else if (ph == 1) begin
         aw = 1'b1; bw = 1'b1;
         bsel = (op == 4 || op == 5 || op == 6);
         ill  = (op >= 11 && op <= 14);
      end else if (op <= 4) begin
         if (ph == 2) begin
            alw = 1'b1; zw = 1'b1;
            alu = (op == 0 || op == 4) ? 3'd1 : 3'(op + 1);
         end else if (trapped) begin
            pcw = 1'b1; jc = 2'd2;
         end else begin
            rw = 1'b1; da = d; dd = 3'd0;
         end
      end else if (op == 5 || op == 6) begin
         if (ph == 2) begin
            alu = 3'd1; alw = 1'b1;
         end else if (ph == 3) begin
            iorm = 1'b1;
            if (op == 5) mw = 1'b1; else memw = 1'b1;
         end else begin
            rw = 1'b1; da = d; dd = 3'd1;
         end
      end else if (op == 7) begin
         pcw = z; jc = 2'd1;
      end else if (op == 8 || op == 9) begin
         pcw = 1'b1; jc = (op == 8) ? 2'd2 : 2'd3;
      end else if (op == 10) begin
         rw = 1'b1; da = d; dd = 3'd2;
      end else if (op == 15) begin
         hlt = 1'b1;
      end
      return {irw, pcw, aw, bw, alw, mw, memw, rw, zw, iorm, asel, bsel, its,
              alu, jc, da, dd, hlt, ill};
   endfunction

   // Drive one cycle of inputs at the falling edge and post its expectation
   task automatic step(input logic rst_v, input logic run_v, input logic [3:0] op_v,
                       input logic [1:0] d_v, input logic z_v, input logic v_v,
                       input logic [24:0] e, input logic et, input logic chk_st);
      @(negedge Clock);
      Reset        = rst_v;
      bus.run      = run_v;
      bus.opcode   = op_v;
      bus.irDest   = d_v;
      bus.isZero   = z_v;
      bus.overflow = v_v;
      exp_vec      = e;
      exp_trap     = et;
      exp_chk_st   = chk_st;
      exp_valid    = 1'b1;
   endtask

   // Reset or IDLE cycle: every output must be zero, state code 0
   task automatic quiet_step(input logic rst_v, input logic run_v);
      step(rst_v, run_v, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           '0, 1'b0, 1'b1);
   endtask

   // One instruction from its fetch; zf/vf < 0 randomise isZero/overflow,
   // abort_ph >= 0 asserts Reset at that cycle of the instruction.
   task automatic do_instr(input int op, input logic [1:0] d, input int zf,
                           input int vf, input int abort_ph);
      int         len;
      logic       z, v, r, trapped;
      logic [3:0] opv;
      logic [1:0] dv;
      trapped = 1'b0;
      len = (op == 15) ? 12 : ilen(op);
      for (int ph = 0; ph < len; ph++) begin
         z   = (zf < 0) ? 1'($urandom) : 1'(zf);
         v   = (vf < 0) ? 1'($urandom) : 1'(vf);
         r   = (op == 15) ? 1'(ph) : 1'($urandom);
         opv = (ph == 0) ? 4'($urandom) : 4'(op);
         dv  = (ph == 0) ? 2'($urandom) : d;
         if (ph == abort_ph) begin
            step(1'b0, r, opv, dv, z, v, '0, 1'b0, 1'b1);
            return;
         end
`ifdef PROC_CTRL_OVF_TRAP_EN
         if (ph == 2 && (op == 0 || op == 1 || op == 4)) trapped = v;
`endif
         step(1'b1, r, opv, dv, z, v, model_out(op, ph, d, z, trapped),
              (ph == 3) && trapped, 1'b0);
      end
   endtask

   // Compare process: checks DUT outputs every cycle, away from the clock edge
   initial begin
      logic [24:0] act;
      forever begin
         @(negedge Clock);
         #2;
         cyc++;
         if (exp_valid) begin
            act = {bus.IRwrite, bus.PCwrite, bus.Awrite, bus.Bwrite, bus.ALUwrite,
                   bus.Mwrite, bus.MemWrite, bus.RegWrite, bus.isZeroWrite, bus.IorM,
                   bus.Asel, bus.Bsel, bus.ItypeSel, bus.ALUctrl, bus.jControl,
                   bus.destAddr, bus.destData, bus.halted, bus.illegal};
            checks++;
            if (act !== exp_vec) begin
               errors++;
               $display("FAIL outputs cyc=%0d got %b expected %b", cyc, act, exp_vec);
            end
            if (exp_chk_st) begin
               checks++;
               if (bus.state !== 4'd0) begin
                  errors++;
                  $display("FAIL state cyc=%0d got %0d expected 0", cyc, bus.state);
               end
            end
`ifdef PROC_CTRL_OVF_TRAP_EN
            checks++;
            if (bus.trap !== exp_trap) begin
               errors++;
               $display("FAIL trap cyc=%0d got %b expected %b", cyc, bus.trap, exp_trap);
            end
`endif
            if (lat_arm && bus.IRwrite === 1'b1) fetch_t.push_back(cyc);
         end
      end
   end

   // Stimulus
   initial begin
      int lat_exp[5] = '{4, 5, 4, 3, 3};
      bus.run = 1'b0; bus.opcode = 4'd0; bus.irDest = 2'd0;
      bus.isZero = 1'b0; bus.overflow = 1'b0;

      // reset held, then released with run low: IDLE, all zero
      quiet_step(1'b0, 1'b1);
      quiet_step(1'b0, 1'b0);
      quiet_step(1'b1, 1'b0);
      quiet_step(1'b1, 1'b0);
      quiet_step(1'b1, 1'b1);

      // directed: ADD 0x0400, LW, SW, BEQZ z=0, BEQZ z=1, illegal 0xC
      lat_arm = 1'b1;
      do_instr(0, 2'd1, -1, 0, -1);
      do_instr(5, 2'd2, -1, -1, -1);
      do_instr(6, 2'd3, -1, -1, -1);
      do_instr(7, 2'd0, 0, -1, -1);
      do_instr(7, 2'd0, 1, -1, -1);
      do_instr(12, 2'd1, -1, -1, -1);
      lat_arm = 1'b0;

      // randomized instruction stream, all non-halting opcodes
      for (int i = 0; i < 60; i++)
         do_instr($urandom_range(0, 14), 2'($urandom), -1, -1, -1);

`ifdef PROC_CTRL_OVF_TRAP_EN
      // ADD overflowing in execute must trap instead of writing back
      do_instr(0, 2'd2, -1, 1, -1);
      do_instr(4, 2'd1, -1, 1, -1);
      do_instr(2, 2'd1, -1, 1, -1);
`endif

      // reset in the middle of a load's memory read, release with run low
      do_instr(5, 2'd1, -1, -1, 3);
      quiet_step(1'b0, 1'b1);
      quiet_step(1'b1, 1'b0);
      quiet_step(1'b1, 1'b0);
      quiet_step(1'b1, 1'b1);

      // HALT, held for 10 cycles with run toggling
      do_instr(15, 2'd0, -1, -1, -1);
      #3;
      exp_valid = 1'b0;

      // fetch-to-fetch latency of the directed instructions
      checks++;
      if (fetch_t.size() != 6) begin
         errors++;
         $display("FAIL fetch_count got %0d expected 6", fetch_t.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (fetch_t[k+1] - fetch_t[k] != lat_exp[k]) begin
               errors++;
               $display("FAIL latency_%0d got %0d expected %0d", k,
                        fetch_t[k+1] - fetch_t[k], lat_exp[k]);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
